// File: rtl/cache_pkg.sv
// Shared types and constants for the cache bank sequencing controller:
// state encoding, tag-array command codes and beat-count helpers.
package cache_pkg;

  typedef enum logic [3:0] {
    S_INIT,
    S_IDLE,
    S_LOOKUP,
    S_WB_CMD,
    S_WB_DATA,
    S_FILL_CMD,
    S_FILL_DATA,
    S_INSTALL,
    S_RESP
  } cache_state_e;

  localparam logic [2:0] REP_RESET   = 3'b000;
  localparam logic [2:0] REP_INSTALL = 3'b001;
  localparam logic [2:0] REP_VICTIM  = 3'b010;
  localparam logic [2:0] REP_FILL    = 3'b011;
  localparam logic [2:0] REP_HOLD    = 3'b100;

  // Memory beats needed to move one cache line.
  function automatic int beats(input int block_size, input int data_width);
    return ((2 ** block_size) * 8) / data_width;
  endfunction

  // Counter width; a single-beat line still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cache_beat_counter.sv
// Modulo-BEATS beat counter for line transfers; wraps to zero on the last beat.
module cache_beat_counter #(
  parameter int BEATS = 8,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] idx,
  output logic         last
);

  logic [W-1:0] idx_reg;

  assign idx  = idx_reg;
  assign last = (idx_reg == W'(BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg <= '0;
    end else if (clr) begin
      idx_reg <= '0;
    end else if (inc) begin
      idx_reg <= last ? '0 : idx_reg + 1'b1;
    end
  end

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Cache bank sequencer: lookup, optional dirty write-back, line fill and install,
// plus the memory command/beat handshake and the data-array beat index.
module cache_ctrl_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_SIZE  = 32,
  parameter int BLOCK_SIZE = 6,
  parameter int INDEX_SIZE = 7,
  parameter int DATA_WIDTH = 64,
  localparam int BEATS     = beats(BLOCK_SIZE, DATA_WIDTH),
  localparam int BW        = idx_width(BEATS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req_valid,
  output logic                 cpu_req_ready,
  input  logic [ADDR_SIZE-1:0] cpu_req_addr,
  input  logic                 cpu_req_write,
  output logic                 cpu_resp_valid,
  output logic                 cpu_resp_hit,
  output logic [ADDR_SIZE-1:0] lk_addr,
  input  logic                 tag_match,
  input  logic                 tag_valid,
  input  logic                 line_dirty,
  input  logic [ADDR_SIZE-1:0] tag_addr,
  output logic [2:0]           replace,
  output logic                 lru_update,
  output logic                 dirty_set,
  output logic                 dirty_clr,
  output logic                 mem_cmd_valid,
  input  logic                 mem_cmd_ready,
  output logic                 mem_cmd_write,
  output logic [ADDR_SIZE-1:0] mem_cmd_addr,
  input  logic                 mem_beat_valid,
  output logic [BW-1:0]        beat_idx,
  output logic                 fill_we
);

  if (BLOCK_SIZE + INDEX_SIZE >= ADDR_SIZE) begin : g_bad_geometry
    $error("cache_ctrl_fsm: offset and index fields leave no tag bits");
  end

  localparam logic [ADDR_SIZE-1:0] LINE_MASK = {ADDR_SIZE{1'b1}} << BLOCK_SIZE;

  cache_state_e         state_reg, state_next;
  logic [ADDR_SIZE-1:0] lk_addr_reg;
  logic                 wr_reg;
  logic                 hit_reg;
  logic                 accept;
  logic                 beat_inc;
  logic                 beat_last;

  cache_beat_counter #(
    .BEATS(BEATS),
    .W    (BW)
  ) u_beat_counter (
    .clk (clk),
    .rst (rst),
    .inc (beat_inc),
    .clr (state_reg == S_IDLE),
    .idx (beat_idx),
    .last(beat_last)
  );

  assign lk_addr      = lk_addr_reg;
  // The tag array presents the victim or fill line depending on replace.
  assign mem_cmd_addr = tag_addr & LINE_MASK;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_INIT;
      lk_addr_reg <= '0;
      wr_reg      <= 1'b0;
      hit_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        lk_addr_reg <= cpu_req_addr;
        wr_reg      <= cpu_req_write;
      end
      if (state_reg == S_LOOKUP) begin
        hit_reg <= tag_match;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    replace        = REP_HOLD;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_hit   = 1'b0;
    lru_update     = 1'b0;
    dirty_set      = 1'b0;
    dirty_clr      = 1'b0;
    mem_cmd_valid  = 1'b0;
    mem_cmd_write  = 1'b0;
    fill_we        = 1'b0;
    beat_inc       = 1'b0;
    accept         = 1'b0;
    case (state_reg)
      S_INIT: begin
        replace    = REP_RESET;
        state_next = S_IDLE;
      end
      S_IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) begin
          accept     = 1'b1;
          state_next = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (tag_match) begin
          lru_update = 1'b1;
          dirty_set  = wr_reg;
          state_next = S_RESP;
        end else if (tag_valid && line_dirty) begin
          state_next = S_WB_CMD;
        end else begin
          state_next = S_FILL_CMD;
        end
      end
      S_WB_CMD: begin
        replace       = REP_VICTIM;
        mem_cmd_valid = 1'b1;
        mem_cmd_write = 1'b1;
        if (mem_cmd_ready) state_next = S_WB_DATA;
      end
      S_WB_DATA: begin
        beat_inc = mem_beat_valid;
        if (mem_beat_valid && beat_last) begin
          dirty_clr  = 1'b1;
          state_next = S_FILL_CMD;
        end
      end
      S_FILL_CMD: begin
        replace       = REP_FILL;
        mem_cmd_valid = 1'b1;
        if (mem_cmd_ready) state_next = S_FILL_DATA;
      end
      S_FILL_DATA: begin
        fill_we  = mem_beat_valid;
        beat_inc = mem_beat_valid;
        if (mem_beat_valid && beat_last) state_next = S_INSTALL;
      end
      S_INSTALL: begin
        replace    = REP_INSTALL;
        lru_update = 1'b1;
        dirty_set  = wr_reg;
        state_next = S_RESP;
      end
      S_RESP: begin
        cpu_resp_valid = 1'b1;
        cpu_resp_hit   = hit_reg;
        state_next     = S_IDLE;
      end
      default: state_next = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed and randomized bench for cache_ctrl_fsm; the bench plays the tag
// array and the memory adapter and predicts each transaction from the rules.
module tb_cache_ctrl_fsm;

  localparam int BEATS = 8;
  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFC0;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_valid, cpu_req_ready, cpu_req_write;
  logic [31:0] cpu_req_addr;
  logic        cpu_resp_valid, cpu_resp_hit;
  logic [31:0] lk_addr;
  logic        tag_match, tag_valid, line_dirty;
  logic [31:0] tag_addr;
  logic [2:0]  replace;
  logic        lru_update, dirty_set, dirty_clr;
  logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_write;
  logic [31:0] mem_cmd_addr;
  logic        mem_beat_valid;
  logic [2:0]  beat_idx;
  logic        fill_we;

  int errors = 0;
  int checks = 0;

  cache_ctrl_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_req_valid (cpu_req_valid),
    .cpu_req_ready (cpu_req_ready),
    .cpu_req_addr  (cpu_req_addr),
    .cpu_req_write (cpu_req_write),
    .cpu_resp_valid(cpu_resp_valid),
    .cpu_resp_hit  (cpu_resp_hit),
    .lk_addr       (lk_addr),
    .tag_match     (tag_match),
    .tag_valid     (tag_valid),
    .line_dirty    (line_dirty),
    .tag_addr      (tag_addr),
    .replace       (replace),
    .lru_update    (lru_update),
    .dirty_set     (dirty_set),
    .dirty_clr     (dirty_clr),
    .mem_cmd_valid (mem_cmd_valid),
    .mem_cmd_ready (mem_cmd_ready),
    .mem_cmd_write (mem_cmd_write),
    .mem_cmd_addr  (mem_cmd_addr),
    .mem_beat_valid(mem_beat_valid),
    .beat_idx      (beat_idx),
    .fill_we       (fill_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic clear_inputs();
    cpu_req_valid  = 1'b0;
    cpu_req_addr   = '0;
    cpu_req_write  = 1'b0;
    tag_match      = 1'b0;
    tag_valid      = 1'b0;
    line_dirty     = 1'b0;
    tag_addr       = '0;
    mem_cmd_ready  = 1'b0;
    mem_beat_valid = 1'b0;
  endtask

  // Called with rst already high: hold it, check reset values, release.
  task automatic reset_release();
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_replace", {29'd0, replace}, 32'd0);
      chk("rst_ready", cpu_req_ready, 1'b0);
      chk("rst_resp", cpu_resp_valid, 1'b0);
      chk("rst_cmd_valid", mem_cmd_valid, 1'b0);
      chk("rst_beat_idx", {29'd0, beat_idx}, 32'd0);
      chk("rst_lk_addr", lk_addr, 32'd0);
      chk("rst_pulses", {29'd0, lru_update, dirty_set, dirty_clr}, 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("init_replace", {29'd0, replace}, 32'd0);
    chk("init_ready", cpu_req_ready, 1'b0);
    @(posedge clk); #1;
    chk("idle_replace", {29'd0, replace}, 32'd4);
    chk("idle_ready", cpu_req_ready, 1'b1);
    $display("reset released: replace=%0d ready=%0d", replace, cpu_req_ready);
  endtask

  // One CPU request. The bench models the tag array (tag_addr follows replace)
  // and a memory that accepts a command after `delay` waiting cycles and then
  // returns BEATS beats, one every gap+1 cycles.
  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic m,
                         input logic v, input logic d, input logic [31:0] victim,
                         input int delay, input int gap, input int abort_at,
                         output bit aborted);
    bit          exp_wb, exp_fill, got, burst_on, burst_fill;
    int          ncmd_exp, cmds_done, cmd_wait, k, gapc, fill_beats, cyc, exp_lat;
    int          n_lru, n_dset, n_dclr, n_inst, n_fwe;
    logic        exp_w;
    logic [31:0] exp_a;
    exp_wb   = !m && v && d;
    exp_fill = !m;
    ncmd_exp = int'(exp_wb) + int'(exp_fill);
    exp_lat  = 1 + ncmd_exp * (delay + 1 + (BEATS - 1) * (gap + 1) + 1) + int'(exp_fill) + 1;
    got = 0; burst_on = 0; burst_fill = 0; aborted = 0;
    cmds_done = 0; cmd_wait = 0; k = 0; gapc = 0; fill_beats = 0;
    n_lru = 0; n_dset = 0; n_dclr = 0; n_inst = 0; n_fwe = 0;

    chk("req_ready", cpu_req_ready, 1'b1);
    cpu_req_valid = 1'b1;
    cpu_req_addr  = addr;
    cpu_req_write = wr;
    @(posedge clk); #1;
    cyc = 1;
    while (!got && !aborted && cyc < 600) begin
      cpu_req_valid = 1'($urandom_range(0, 1));
      cpu_req_addr  = $urandom;
      cpu_req_write = 1'($urandom_range(0, 1));
      if (cyc == 1) begin
        tag_match = m; tag_valid = v; line_dirty = d;
      end else begin
        tag_match  = 1'($urandom_range(0, 1));
        tag_valid  = 1'($urandom_range(0, 1));
        line_dirty = 1'($urandom_range(0, 1));
      end
      case (replace)
        3'b010:  tag_addr = victim;
        3'b011:  tag_addr = addr;
        default: tag_addr = $urandom;
      endcase
      mem_beat_valid = 1'b0;
      mem_cmd_ready  = 1'b0;
      if (burst_on) begin
        mem_beat_valid = (gapc == 0);
      end else if (mem_cmd_valid) begin
        mem_cmd_ready = (cmd_wait >= delay);
      end else begin
        mem_beat_valid = 1'($urandom_range(0, 1));
        mem_cmd_ready  = 1'($urandom_range(0, 1));
      end
      #1;
      chk("lk_addr", lk_addr, addr);
      chk("busy_ready", cpu_req_ready, 1'b0);
      n_lru  += int'(lru_update);
      n_dset += int'(dirty_set);
      n_dclr += int'(dirty_clr);
      n_inst += int'(replace == 3'b001);
      n_fwe  += int'(fill_we);
      if (mem_cmd_valid) begin
        exp_w = exp_wb && (cmds_done == 0);
        exp_a = exp_w ? (victim & LINE_MASK) : (addr & LINE_MASK);
        chk("cmd_write", mem_cmd_write, exp_w);
        chk("cmd_addr", mem_cmd_addr, exp_a);
        chk("cmd_replace", {29'd0, replace}, exp_w ? 32'd2 : 32'd3);
        if (mem_cmd_ready) begin
          cmds_done++; cmd_wait = 0;
          burst_on = 1; burst_fill = !exp_w; k = 0; gapc = 0;
        end else begin
          cmd_wait++;
        end
      end else if (burst_on) begin
        if (mem_beat_valid) begin
          chk("beat_idx", {29'd0, beat_idx}, k);
          chk("fill_we", fill_we, burst_fill);
          if (burst_fill) fill_beats++;
          k++;
          gapc = gap;
          if (k == BEATS) burst_on = 0;
          if (burst_fill && fill_beats == abort_at) aborted = 1;
        end else begin
          gapc--;
        end
      end else begin
        chk("stray_fill_we", fill_we, 1'b0);
      end
      if (cpu_resp_valid) begin
        chk("resp_hit", cpu_resp_hit, m);
        chk("latency", cyc, exp_lat);
        got = 1;
      end
      if (!got && !aborted) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (aborted) begin
      $display("txn addr=%h wr=%0d aborted after %0d fill beats", addr, wr, fill_beats);
      return;
    end
    chk("resp_seen", got, 1'b1);
    chk("n_lru", n_lru, 1);
    chk("n_dirty_set", n_dset, int'(wr));
    chk("n_dirty_clr", n_dclr, int'(exp_wb));
    chk("n_install", n_inst, int'(exp_fill));
    chk("n_fill_we", n_fwe, exp_fill ? BEATS : 0);
    chk("n_cmds", cmds_done, ncmd_exp);
    cpu_req_valid = 1'b0;
    @(posedge clk); #1;
    chk("resp_one_cycle", cpu_resp_valid, 1'b0);
    chk("back_idle", cpu_req_ready, 1'b1);
    $display("txn addr=%h wr=%0d match=%0d valid=%0d dirty=%0d delay=%0d gap=%0d cycles=%0d cmds=%0d",
             addr, wr, m, v, d, delay, gap, cyc, cmds_done);
  endtask

  initial begin
    bit ab;
    clear_inputs();
    rst = 1'b1;
    reset_release();

    // Load hit.
    run_txn(32'h0000_1040, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 0, 0, -1, ab);
    // Clean store miss.
    run_txn(32'h0000_1040, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0, -1, ab);
    // Dirty miss with command backpressure.
    run_txn(32'h0000_2080, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0009_F0C5, 4, 0, -1, ab);
    // Gapped beats during fill.
    run_txn(32'h0000_30C4, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1, 1, -1, ab);

    // Reset in the middle of a fill, right after beat 3.
    run_txn(32'h0000_4100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0, 4, ab);
    chk("abort_reached", ab, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_replace", {29'd0, replace}, 32'd0);
    chk("midrst_beat_idx", {29'd0, beat_idx}, 32'd0);
    chk("midrst_fill_we", fill_we, 1'b0);
    chk("midrst_lk_addr", lk_addr, 32'd0);
    chk("midrst_resp", cpu_resp_valid, 1'b0);
    clear_inputs();
    reset_release();
    run_txn(32'h0000_4100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0, -1, ab);

    for (int i = 0; i < 40; i++) begin
      run_txn($urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
              $urandom_range(0, 3), $urandom_range(0, 2), -1, ab);
      clear_inputs();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        chk("idle_gap_ready", cpu_req_ready, 1'b1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
